// File: rtl/vga_fb_writer.sv
// Write side of the VGA frame buffer: packs 8-bit palette indices four per word
// and writes them to the frame RAM, or fills the whole frame with one index.
module vga_fb_writer #(
    parameter int WORDS = 76800,
    parameter int AW    = 19
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iSTART,
    input  logic          iCLEAR,
    input  logic [7:0]    iCLEAR_IDX,
    input  logic          iPIX_VALID,
    input  logic [7:0]    iPIX,
    output logic          oPIX_READY,
    input  logic          iFLUSH,
    output logic          oWE,
    output logic [AW-1:0] oADDR,
    output logic [31:0]   oWD,
    output logic          oBUSY,
    output logic          oFRAME_DONE,
    output logic [1:0]    oSTATE
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    state_t        state;
    logic [1:0]    lane;
    logic [31:0]   pack;
    logic [AW-1:0] waddr;
    logic [7:0]    clear_idx;

    logic          accept;
    logic [1:0]    lane_nx;
    logic [31:0]   pack_nx;
    logic          stream_wr;

    // Handshake: a pixel transfers on any clock edge where iPIX_VALID and
    // oPIX_READY are both high; the producer holds iPIX stable until then.
    always_comb begin
        accept  = iPIX_VALID && oPIX_READY;
        lane_nx = lane;
        pack_nx = pack;
        if (accept) begin
            pack_nx[{lane, 3'b000} +: 8] = iPIX;
            lane_nx = lane + 2'd1;
        end
        // A flush only matters if, after this cycle's pixel, some lane is filled.
        stream_wr = (state == STREAM) &&
                    ((accept && lane == 2'd3) || (iFLUSH && lane_nx != 2'd0));
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= IDLE;
            lane        <= 2'd0;
            pack        <= 32'd0;
            waddr       <= '0;
            clear_idx   <= 8'd0;
            oWE         <= 1'b0;
            oADDR       <= '0;
            oWD         <= 32'd0;
            oPIX_READY  <= 1'b0;
            oBUSY       <= 1'b0;
            oFRAME_DONE <= 1'b0;
        end else begin
            oWE         <= 1'b0;
            oFRAME_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (iCLEAR) begin
                        // Word 0 of the clear goes out on the entry edge.
                        clear_idx <= iCLEAR_IDX;
                        lane      <= 2'd0;
                        pack      <= 32'd0;
                        oWE       <= 1'b1;
                        oADDR     <= '0;
                        oWD       <= {4{iCLEAR_IDX}};
                        if (LAST_ADDR == '0) begin
                            oFRAME_DONE <= 1'b1;
                            waddr       <= '0;
                        end else begin
                            state <= CLEAR;
                            oBUSY <= 1'b1;
                            waddr <= ADDR_ONE;
                        end
                    end else if (iSTART) begin
                        state      <= STREAM;
                        oPIX_READY <= 1'b1;
                        oBUSY      <= 1'b1;
                        waddr      <= '0;
                        lane       <= 2'd0;
                        pack       <= 32'd0;
                    end
                end
                STREAM: begin
                    if (stream_wr) begin
                        oWE   <= 1'b1;
                        oADDR <= waddr;
                        oWD   <= pack_nx;
                        lane  <= 2'd0;
                        pack  <= 32'd0;
                        if (waddr == LAST_ADDR) begin
                            oFRAME_DONE <= 1'b1;
                            oPIX_READY  <= 1'b0;
                            oBUSY       <= 1'b0;
                            waddr       <= '0;
                            state       <= IDLE;
                        end else begin
                            waddr <= waddr + ADDR_ONE;
                        end
                    end else begin
                        lane <= lane_nx;
                        pack <= pack_nx;
                    end
                end
                CLEAR: begin
                    oWE   <= 1'b1;
                    oADDR <= waddr;
                    oWD   <= {4{clear_idx}};
                    if (waddr == LAST_ADDR) begin
                        oFRAME_DONE <= 1'b1;
                        oBUSY       <= 1'b0;
                        waddr       <= '0;
                        state       <= IDLE;
                    end else begin
                        waddr <= waddr + ADDR_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oSTATE = state;

endmodule

// File: tb/tb_vga_fb_writer.sv
// Bench for vga_fb_writer with a 4-word frame: vector table drives the inputs,
// expected RAM writes go into a queue and are matched against oWE cycles.
module tb_vga_fb_writer;

    localparam int WORDS = 4;
    localparam int AW    = 19;
    localparam int W     = 16 + 1 + AW + 32;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [7:0]    clear_idx = 8'h00;
    logic          pix_valid = 1'b0;
    logic [7:0]    pix = 8'h00;
    logic          flush = 1'b0;
    logic          pix_ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic          busy;
    logic          frame_done;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    vga_fb_writer #(.WORDS(WORDS), .AW(AW)) dut (
        .iCLK(clk), .iRST(rst), .iSTART(start), .iCLEAR(clear),
        .iCLEAR_IDX(clear_idx), .iPIX_VALID(pix_valid), .iPIX(pix),
        .oPIX_READY(pix_ready), .iFLUSH(flush), .oWE(we), .oADDR(addr),
        .oWD(wd), .oBUSY(busy), .oFRAME_DONE(frame_done), .oSTATE(dbg_state)
    );

    // ---------------- check bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst, start, clear;
        logic [7:0]    idx;
        logic          valid;
        logic [7:0]    pix;
        logic          flush;
        logic          chk, rdy, busy, zero, we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, s, c, input logic [7:0] ix,
                                input logic v, input logic [7:0] p, input logic f,
                                input logic ck, rd, bz, z, w,
                                input logic [AW-1:0] a, input logic [31:0] d,
                                input logic dn);
        vec_t e;
        e.rst = r; e.start = s; e.clear = c; e.idx = ix; e.valid = v; e.pix = p;
        e.flush = f; e.chk = ck; e.rdy = rd; e.busy = bz; e.zero = z; e.we = w;
        e.addr = a; e.data = d; e.done = dn;
        vecs.push_back(e);
    endfunction

    function automatic void st();
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h0, 1'b0);
    endfunction
    function automatic void idle(input logic rd, input logic bz);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, rd, bz, 1'b0, 1'b0, '0, 32'h0, 1'b0);
    endfunction
    function automatic void p(input logic [7:0] px);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, px, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 32'h0, 1'b0);
    endfunction
    function automatic void pw(input logic [7:0] px, input logic f, input logic [AW-1:0] a,
                               input logic [31:0] d, input logic dn);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, px, f, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, a, d, dn);
    endfunction
    function automatic void fw(input logic [AW-1:0] a, input logic [31:0] d, input logic dn);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, a, d, dn);
    endfunction
    function automatic void quiet_zero();
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 32'h0, 1'b0);
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: cycle %0d addr %0h data %0h, no write expected",
                         cyc, addr, wd);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_cycle", 64'(cyc), 64'(mon_e[W-1:W-16]));
                check("wr_addr", 64'(addr), 64'(mon_e[AW+31:32]));
                check("wr_data", 64'(wd), 64'(mon_e[31:0]));
                check("wr_done", 64'(frame_done), 64'(mon_e[AW+32]));
            end
        end else begin
            if (frame_done === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL done_without_we: cycle %0d got 1 expected 0", cyc);
            end
            if (exp_q.size() > 0 && int'(exp_q[0][W-1:W-16]) <= cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_write: cycle %0d got no write expected addr %0h data %0h",
                         cyc, mon_e[AW+31:32], mon_e[31:0]);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        if (v.zero)
            check($sformatf("outputs_zero@%0d", idx),
                  64'({we, addr, wd, pix_ready, busy, frame_done}), 64'd0);
        if (v.chk) begin
            check($sformatf("ready@%0d", idx), 64'(pix_ready), 64'(v.rdy));
            check($sformatf("busy@%0d", idx), 64'(busy), 64'(v.busy));
        end
        rst       = v.rst;
        start     = v.start;
        clear     = v.clear;
        clear_idx = v.idx;
        pix_valid = v.valid;
        pix       = v.pix;
        flush     = v.flush;
        if (v.we)
            exp_q.push_back({16'(cyc + 1), v.done, v.addr, v.data});
    endtask

    logic [31:0] sw [4];

    initial begin
        sw[0] = 32'h03020100; sw[1] = 32'h07060504;
        sw[2] = 32'h0B0A0908; sw[3] = 32'h0F0E0D0C;

        // Stream 16 back-to-back pixels 0x00..0x0F.
        st();
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 3) pw(8'(i), 1'b0, AW'(i / 4), sw[i / 4], (i == 15) ? 1'b1 : 1'b0);
            else            p(8'(i));
        end
        idle(1'b0, 1'b0);

        // Gapped valid, then single-pixel flushes to finish the frame.
        st();
        p(8'hA1); idle(1'b1, 1'b1); idle(1'b1, 1'b1);
        p(8'hB2); idle(1'b1, 1'b1); idle(1'b1, 1'b1);
        p(8'hC3); idle(1'b1, 1'b1); idle(1'b1, 1'b1);
        pw(8'hD4, 1'b0, AW'(0), 32'hD4C3B2A1, 1'b0);
        idle(1'b1, 1'b1);
        pw(8'h99, 1'b1, AW'(1), 32'h00000099, 1'b0);
        pw(8'h5C, 1'b1, AW'(2), 32'h0000005C, 1'b0);
        p(8'h7E); p(8'h6F);
        fw(AW'(3), 32'h00006F7E, 1'b1);
        idle(1'b0, 1'b0);

        // Flush of a partial word, flush on a 4th pixel, flush on empty word.
        st();
        p(8'h11); p(8'h22);
        fw(AW'(0), 32'h00002211, 1'b0);
        p(8'h01); p(8'h02); p(8'h03);
        pw(8'h04, 1'b0, AW'(1), 32'h04030201, 1'b0);
        p(8'h11); p(8'h22); p(8'h33);
        pw(8'h44, 1'b1, AW'(2), 32'h44332211, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        p(8'hDE); p(8'hAD); p(8'hBE);
        pw(8'hEF, 1'b0, AW'(3), 32'hEFBEADDE, 1'b1);
        idle(1'b0, 1'b0);

        // Clear with iSTART held alongside; index changes after it was sampled.
        add(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, AW'(0), 32'h5A5A5A5A, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, AW'(1), 32'h5A5A5A5A, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, AW'(2), 32'h5A5A5A5A, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, AW'(3), 32'h5A5A5A5A, 1'b1);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Reset mid-frame after 6 pixels, then a fresh frame from address 0.
        st();
        p(8'h01); p(8'h02); p(8'h03);
        pw(8'h04, 1'b0, AW'(0), 32'h04030201, 1'b0);
        p(8'h05); p(8'h06);
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 32'h0, 1'b0);
        quiet_zero();
        quiet_zero();
        st();
        p(8'h21); p(8'h22); p(8'h23);
        pw(8'h24, 1'b0, AW'(0), 32'h24232221, 1'b0);
        pw(8'h31, 1'b1, AW'(1), 32'h00000031, 1'b0);
        pw(8'h32, 1'b1, AW'(2), 32'h00000032, 1'b0);
        pw(8'h33, 1'b1, AW'(3), 32'h00000033, 1'b1);
        idle(1'b0, 1'b0);

        // Power-on reset values.
        repeat (3) @(negedge clk);
        check("rst_we", 64'(we), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_wd", 64'(wd), 64'd0);
        check("rst_ready", 64'(pix_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_fb_writer.md
# vga_fb_writer

Write-side companion to the VGA scan-out path. Accepts a stream of 8-bit palette indices and packs four consecutive indices into each 32-bit word of the frame RAM. Issues single-cycle writes on the RAM write port (CLK/WE/ADDRESS/WD) at word addresses 0..WORDS-1. Also provides a full-frame clear mode. Lane k of a word holds the pixel that scan-out displays when its chunk counter equals k.

## Interface
Parameters:
- WORDS, 76800, number of 32-bit words per frame (640x480 / 4).
- AW, 19, RAM word-address width.

Ports:
- iCLK  in  1  system clock; also drives the RAM write port.
- iRST  in  1  synchronous, active-high reset.
- iSTART  in  1  in IDLE, begins a stream frame at address 0.
- iCLEAR  in  1  in IDLE, begins a clear frame at address 0.
- iCLEAR_IDX  in  8  index replicated into all 4 lanes during clear; sampled with iCLEAR.
- iPIX_VALID  in  1  iPIX is valid.
- iPIX  in  8  palette index.
- oPIX_READY  out  1  pixel accepted when iPIX_VALID && oPIX_READY.
- iFLUSH  in  1  in STREAM, force a write of the partially filled word.
- oWE  out  1  RAM write enable, one cycle per word.
- oADDR  out  AW  RAM word address, valid while oWE=1.
- oWD  out  32  RAM write data, valid while oWE=1.
- oBUSY  out  1  high in STREAM or CLEAR.
- oFRAME_DONE  out  1  one-cycle pulse coincident with the final word write.

## Operation
- States:
  - IDLE: oPIX_READY=0.
  - STREAM: accepts pixels.
  - CLEAR: writes one word per cycle.
- IDLE transitions:
  - iCLEAR=1 -> CLEAR. iCLEAR takes priority if iSTART is also high.
  - Else iSTART=1 -> STREAM.
  - Entry into either state clears the word address and the lane counter to 0.
- STREAM packing:
  - A 2-bit lane counter selects the lane for each accepted pixel: lane k is bits [8k+7:8k].
  - Pixel on lane 3 completes the word. The next cycle drives oWE=1 with oADDR = current word address, then the address increments and the lane counter wraps to 0.
  - The pack register is separate from the write register, so throughput is 1 pixel/cycle with no ready bubble.
- iFLUSH in STREAM with lane counter != 0 (after counting any pixel accepted that same cycle):
  - Writes the partial word next cycle; unfilled lanes are 0x00.
  - Address increments and the lane counter resets.
  - If the lane counter is 0, iFLUSH is a no-op.
- Final word: the write to address WORDS-1 asserts oFRAME_DONE in the same cycle as its oWE. The state returns to IDLE that cycle.
- oPIX_READY drops the cycle after the pixel completing word WORDS-1 is accepted.
- CLEAR: oWE=1 every cycle for exactly WORDS cycles, with oWD = {4{iCLEAR_IDX latched}} and oADDR = 0..WORDS-1. oPIX_READY stays 0.
- iSTART/iCLEAR while busy are ignored.
- Address arithmetic is AW bits. The address never exceeds WORDS-1 and never wraps within a frame.

## Timing
- Reset value of every output: oWE=0, oADDR=0, oWD=0, oPIX_READY=0, oBUSY=0, oFRAME_DONE=0. The pack register, lane counter and address are all 0.
- Reset mid-frame discards any partial word. No write is issued in the reset cycle or the cycle after.
- All outputs are registered.
- Start latency:
  - STREAM: oPIX_READY=1 and oBUSY=1 one cycle after iSTART is sampled.
  - CLEAR: first oWE one cycle after iCLEAR is sampled.
- Write latency: oWE one cycle after the 4th pixel accept, or one cycle after the iFLUSH sample.
- oWE is never high for two cycles to the same address.
- iPIX_VALID is ignored while oPIX_READY=0.

## Test plan
- Stream, WORDS=4: iSTART, then 16 back-to-back pixels 0x00..0x0F.
  - Writes: addr0=0x03020100, addr1=0x07060504, addr2=0x0B0A0908, addr3=0x0F0E0D0C, each 1 cycle after its 4th accept.
  - oFRAME_DONE high with the addr3 write; oPIX_READY=0 after it.
- Gapped valid, WORDS=4: pixels 0xA1,0xB2,0xC3,0xD4 with 2 idle cycles between each -> single write addr0=0xD4C3B2A1, no extra oWE.
- Flush: 2 pixels 0x11,0x22 then iFLUSH -> addr0=0x00002211. Next 4 pixels land at addr1.
- Flush coincident with the 4th pixel 0x44 -> exactly one write 0x44332211. The flush is a no-op.
- Clear, WORDS=4: iCLEAR with iCLEAR_IDX=0x5A -> 4 consecutive writes of 0x5A5A5A5A to addr0..3, oFRAME_DONE on the 4th. iSTART held high during clear is ignored.
- Reset mid-frame after 6 pixels: no write from the partial word, all outputs 0. A following iSTART writes its first word at addr0.
